// File: rtl/sn_window_decoder.sv
// Stochastic-to-binary decoder: counts ones per window of 2**WIN_LOG2 accepted bits; SN_DEC_BIPOLAR_EN gives signed 2*ones-N.
// Latency: result valid 1 cycle after the window's last accepted bit.
// Backpressure: none on input; a window closing while dout is stalled is dropped and sets sticky overrun.
module sn_window_decoder #(
    parameter int WIN_LOG2 = 3,
`ifdef SN_DEC_BIPOLAR_EN
    localparam int OUT_W = WIN_LOG2 + 2
`else
    localparam int OUT_W = WIN_LOG2 + 1
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sn_bit,
    input  logic                sn_valid,
    output logic [OUT_W-1:0]    dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                overrun,
    output logic [WIN_LOG2-1:0] win_fill
);

    localparam logic [WIN_LOG2-1:0] LAST_FILL = '1;
    localparam logic [OUT_W-1:0]    N_OUT     = OUT_W'(2 ** WIN_LOG2);

    logic [WIN_LOG2-1:0] fill_q, fill_d;
    logic [WIN_LOG2-1:0] ones_q, ones_d;
    logic [OUT_W-1:0]    dout_q, dout_d;
    logic                vld_q, vld_d;
    logic                ovr_q, ovr_d;
    logic [WIN_LOG2:0]   cand;
    logic [OUT_W-1:0]    cand_out;
    logic                accept;
    logic                close;

    assign accept = sn_valid && !clear;
    assign close  = accept && (fill_q == LAST_FILL);
    // Candidate spans 0..N, one bit wider than the running ones count.
    assign cand   = (WIN_LOG2 + 1)'(ones_q) + (WIN_LOG2 + 1)'(sn_bit);

`ifdef SN_DEC_BIPOLAR_EN
    assign cand_out = {cand, 1'b0} - N_OUT;
`else
    assign cand_out = cand;
`endif

    always_comb begin
        fill_d = fill_q;
        ones_d = ones_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;
        if (clear) begin
            fill_d = '0;
            ones_d = '0;
            vld_d  = 1'b0;
            ovr_d  = 1'b0;
        end else begin
            if (accept) begin
                if (close) begin
                    fill_d = '0;
                    ones_d = '0;
                end else begin
                    fill_d = fill_q + WIN_LOG2'(1);
                    ones_d = ones_q + WIN_LOG2'(sn_bit);
                end
            end
            if (close) begin
                if (!vld_q || dout_ready) begin
                    dout_d = cand_out;
                    vld_d  = 1'b1;
                end else begin
                    ovr_d  = 1'b1;
                end
            end else if (vld_q && dout_ready) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            ones_q <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            ones_q <= ones_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign overrun    = ovr_q;
    assign win_fill   = fill_q;

endmodule
